// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that time-shares one non-pipelined 8-bit CORDIC core.
// Out-of-range angles are answered directly with an error result.
module cordic_arbiter #(
  parameter int          N_REQ     = 4,
  parameter int          ID_W      = 2,
  parameter int          LATENCY   = 14,
  parameter logic [7:0]  MAX_ANGLE = 8'd100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_angle,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           core_in,
  input  logic [7:0]           core_sine,
  input  logic [7:0]           core_cosine,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [7:0]           res_sine,
  output logic [7:0]           res_cosine,
  output logic                 res_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ID_W-1:0]   rr_last_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ID_W-1:0]   grant_s;
  logic [ID_W-1:0]   idx_s;
  logic              grant_vld_s;
  logic [7:0]        grant_angle_s;
  logic              accept_s;
  logic              in_range_s;
  logic              cnt_done_s;
  logic              res_fire_s;

  // Round-robin search; walking offsets downwards lets the nearest requester win.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    idx_s       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_s = ID_W'((int'(rr_last_r) + k) % N_REQ);
      if (req_valid[idx_s]) begin
        grant_s     = idx_s;
        grant_vld_s = 1'b1;
      end else begin
        grant_s     = grant_s;
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign grant_angle_s = req_angle[{grant_s, 3'b000} +: 8];
  assign accept_s      = (state_r == IDLE) && grant_vld_s;
  assign in_range_s    = (grant_angle_s <= MAX_ANGLE);
  assign cnt_done_s    = (cnt_r == CNT_W'(LATENCY - 1));
  assign res_fire_s    = res_valid && res_ready;
  assign busy          = (state_r != IDLE);

  // One-hot grant, offered only while idle.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = in_range_s ? RUN : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_done_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RESP: begin
        if (res_fire_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: pointer, latency counter, core angle and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_r  <= ID_W'(N_REQ - 1);
      cnt_r      <= '0;
      core_in    <= 8'd0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_sine   <= 8'd0;
      res_cosine <= 8'd0;
      res_err    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            rr_last_r <= grant_s;
            res_id    <= grant_s;
            if (in_range_s) begin
              core_in <= grant_angle_s;
              cnt_r   <= '0;
            end else begin
              res_err    <= 1'b1;
              res_sine   <= 8'd0;
              res_cosine <= 8'd0;
              res_valid  <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt_r <= cnt_r + CNT_W'(1);
          // Core outputs are trusted only once the full latency has elapsed.
          if (cnt_done_s) begin
            res_sine   <= core_sine;
            res_cosine <= core_cosine;
            res_err    <= 1'b0;
            res_valid  <= 1'b1;
          end
        end
        RESP: begin
          if (res_fire_s) begin
            res_valid <= 1'b0;
          end
        end
        default: begin
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomised scoreboard bench for cordic_arbiter with a delayed real-math CORDIC core model.
module tb_cordic_arbiter;
  localparam int         N_REQ     = 4;
  localparam int         ID_W      = 2;
  localparam int         LATENCY   = 14;
  localparam logic [7:0] MAX_ANGLE = 8'd100;

  logic                 clk;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [8*N_REQ-1:0]   req_angle;
  logic [N_REQ-1:0]     req_ready;
  logic [7:0]           core_in;
  logic [7:0]           core_sine;
  logic [7:0]           core_cosine;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_W-1:0]      res_id;
  logic [7:0]           res_sine;
  logic [7:0]           res_cosine;
  logic                 res_err;
  logic                 busy;

  cordic_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .LATENCY(LATENCY), .MAX_ANGLE(MAX_ANGLE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .core_in(core_in), .core_sine(core_sine), .core_cosine(core_cosine),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_sine(res_sine),
    .res_cosine(res_cosine), .res_err(res_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ang_a [N_REQ];
  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_angle[8*i +: 8] = ang_a[i];
  end

  function automatic logic [7:0] f_sin(input logic [7:0] a);
    real r;
    r = $sin($itor(a) / 64.0) * 64.0;
    return 8'($rtoi(r + 0.5));
  endfunction

  function automatic logic [7:0] f_cos(input logic [7:0] a);
    real r;
    r = $cos($itor(a) / 64.0) * 64.0;
    return 8'($rtoi(r + 0.5));
  endfunction

  // Core model: outputs reflect core_in only after LATENCY edges have been seen.
  logic [7:0] sin_pipe [LATENCY-1];
  logic [7:0] cos_pipe [LATENCY-1];
  always @(posedge clk) begin
    sin_pipe[0] <= f_sin(core_in);
    cos_pipe[0] <= f_cos(core_in);
    for (int i = 1; i < LATENCY - 1; i++) begin
      sin_pipe[i] <= sin_pipe[i-1];
      cos_pipe[i] <= cos_pipe[i-1];
    end
  end
  assign core_sine   = sin_pipe[LATENCY-2];
  assign core_cosine = cos_pipe[LATENCY-2];

  typedef struct {
    logic [ID_W-1:0] id;
    logic [7:0]      sine;
    logic [7:0]      cosine;
    logic            err;
  } res_t;
  res_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Reference model state: one transaction in flight, result due at a known cycle.
  int         cyc = 0;
  bit         m_busy = 1'b0;
  int         m_res_at = 0;
  int         m_rr = N_REQ - 1;
  logic [7:0] m_core = 8'd0;
  int         acc_g = -1;
  int         acc_cyc = 0;
  bit         chk_en = 1'b0;

  // Observations taken from the DUT by the monitor.
  int         rise_cyc = 0;
  logic       prev_rv = 1'b0;
  int         ids_seen[$];
  int         dut_acc[$];
  logic [7:0] last_sine, last_cos;
  logic       last_err;
  int         last_id;

  function automatic int pick(input int rr, input logic [N_REQ-1:0] v);
    for (int k = 1; k <= N_REQ; k++) begin
      if (v[ID_W'((rr + k) % N_REQ)]) return (rr + k) % N_REQ;
    end
    return 0;
  endfunction

  task automatic model_edge();
    int old_c;
    int g;
    logic [7:0] a;
    res_t r;
    old_c = cyc;
    cyc++;
    acc_g = -1;
    if (rst) begin
      m_busy = 1'b0;
      m_rr   = N_REQ - 1;
      m_core = 8'd0;
      exp_q.delete();
    end else if (m_busy) begin
      if (old_c >= m_res_at && res_ready) m_busy = 1'b0;
    end else if (|req_valid) begin
      g = pick(m_rr, req_valid);
      a = ang_a[g];
      m_rr = g;
      r.id = ID_W'(g);
      r.err = (a > MAX_ANGLE);
      r.sine = r.err ? 8'd0 : f_sin(a);
      r.cosine = r.err ? 8'd0 : f_cos(a);
      exp_q.push_back(r);
      if (!r.err) m_core = a;
      m_res_at = cyc + (r.err ? 0 : LATENCY);
      m_busy = 1'b1;
      acc_g = g;
      acc_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    n = 0;
    while (m_busy && n < bound) begin
      tick();
      n++;
    end
    if (m_busy) begin
      n_chk++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, bound);
    end
  endtask

  // Monitor: per-cycle comparison against the model and scoreboard pop on handshake.
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_rdy;
    bit exp_rv;
    if (chk_en) begin
      exp_rv  = m_busy && (cyc >= m_res_at);
      exp_rdy = '0;
      if (!m_busy && (|req_valid)) exp_rdy[ID_W'(pick(m_rr, req_valid))] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("res_valid", 32'(res_valid), 32'(exp_rv));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("core_in", 32'(core_in), 32'(m_core));
      if (|(req_ready & req_valid)) dut_acc.push_back(cyc);
      if (res_valid && !prev_rv) rise_cyc = cyc;
      prev_rv = res_valid;
      if (exp_rv) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard: result expected but queue empty at cycle %0d", cyc);
        end else begin
          chk("res_id", 32'(res_id), 32'(exp_q[0].id));
          chk("res_sine", 32'(res_sine), 32'(exp_q[0].sine));
          chk("res_cosine", 32'(res_cosine), 32'(exp_q[0].cosine));
          chk("res_err", 32'(res_err), 32'(exp_q[0].err));
          if (res_ready) begin
            last_sine = res_sine;
            last_cos  = res_cosine;
            last_err  = res_err;
            last_id   = int'(res_id);
            ids_seen.push_back(int'(res_id));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) ang_a[i] = 8'd0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_core_in", 32'(core_in), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_sine", 32'(res_sine), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single in-range request.
    ang_a[0] = 8'h2B;
    req_valid = 4'b0001;
    res_ready = 1'b1;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("t1_core_in", 32'(core_in), 32'h2B);
    wait_idle("t1", 40);
    chk("t1_latency", 32'(rise_cyc - acc_cyc), 32'(LATENCY));
    chk("t1_sine", 32'(last_sine), 32'h28);
    chk("t1_cosine", 32'(last_cos), 32'h32);
    chk("t1_id", 32'(last_id), 32'd0);
    chk("t1_err", 32'(last_err), 32'd0);

    // All requesters continuously valid after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ang_a[0] = 8'h10; ang_a[1] = 8'h20; ang_a[2] = 8'h30; ang_a[3] = 8'h40;
    ids_seen.delete();
    dut_acc.delete();
    req_valid = 4'b1111;
    for (int n = 0; n < 200 && ids_seen.size() < 5; n++) tick();
    req_valid = '0;
    wait_idle("t2", 40);
    chk("t2_count", 32'(ids_seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < ids_seen.size(); i++)
      chk("t2_id_order", 32'(ids_seen[i]), 32'(i % N_REQ));
    for (int i = 1; i < dut_acc.size(); i++)
      chk("t2_accept_gap", 32'(dut_acc[i] - dut_acc[i-1]), 32'(LATENCY + 2));

    // Out-of-range angle is rejected without touching the core.
    ang_a[2] = 8'h65;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_idle("t3", 10);
    chk("t3_latency", 32'(rise_cyc - acc_cyc), 32'd0);
    chk("t3_id", 32'(last_id), 32'd2);
    chk("t3_err", 32'(last_err), 32'd1);
    chk("t3_sine", 32'(last_sine), 32'd0);
    chk("t3_cosine", 32'(last_cos), 32'd0);
    chk("t3_core_in", 32'(core_in), 32'h10);

    // Consumer stall with another requester waiting.
    ang_a[1] = 8'h20;
    ang_a[3] = 8'h30;
    res_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1000;
    for (int n = 0; n < 40 && cyc < m_res_at; n++) tick();
    for (int n = 0; n < 5; n++) begin
      chk("t4_stall_valid", 32'(res_valid), 32'd1);
      chk("t4_stall_sine", 32'(res_sine), 32'(f_sin(8'h20)));
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    #1;
    chk("t4_drop", 32'(res_valid), 32'd0);
    chk("t4_next_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    wait_idle("t4", 40);
    chk("t4_second_id", 32'(last_id), 32'd3);

    // Reset in the middle of RUN.
    ang_a[0] = 8'h38;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    for (int n = 0; n < 7; n++) tick();
    ang_a[3] = 8'h48;
    req_valid = 4'b1001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    chk("t5_core_in", 32'(core_in), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b1000;
    wait_idle("t5a", 40);
    chk("t5_first_id", 32'(last_id), 32'd0);
    tick();
    req_valid = '0;
    wait_idle("t5b", 40);
    chk("t5_second_id", 32'(last_id), 32'd3);

    // Boundary angles.
    ang_a[1] = 8'h00;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_idle("t6a", 40);
    chk("t6_zero_err", 32'(last_err), 32'd0);
    chk("t6_zero_cos", 32'(last_cos), 32'(f_cos(8'h00)));
    ang_a[2] = 8'h64;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_idle("t6b", 40);
    chk("t6_max_err", 32'(last_err), 32'd0);
    chk("t6_max_sine", 32'(last_sine), 32'(f_sin(8'h64)));
    ang_a[3] = 8'hFF;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    wait_idle("t6c", 10);
    chk("t6_ff_err", 32'(last_err), 32'd1);
    chk("t6_ff_id", 32'(last_id), 32'd3);

    // Random traffic; waiting requesters keep their angle until accepted.
    for (int n = 0; n < 600; n++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (acc_g == i) begin
          req_valid[i] = $urandom_range(0, 1) == 1;
          ang_a[i] = 8'($urandom_range(0, 130));
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            ang_a[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 130));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    wait_idle("rand", 40);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
